hv_memory_loader_eeg: RTL and testbench

//  Write-side front end for the EEG item/projection memories (IM, PROJM_POS, PROJM_NEG).
//  - Accepts hypervector rows as a stream of CHUNK_WIDTH-bit chunks over valid/ready.
//  - Assembles one full `HV_DIMENSION row for each of the three memories.
//  - Issues one shared active-low write strobe that writes all three memories at the same address.
//  - Sits between the configuration/scan loader and the EEG memory wrapper; the top level muxes addresses by busy.

---
 rtl/hv_memory_loader_eeg.sv | 133 +++++++++++++
 tb/tb_hv_memory_loader_eeg.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hv_memory_loader_eeg.sv
// Chunked write-side loader for the EEG IM / PROJM_POS / PROJM_NEG memories.
// Assembles one row per memory from CHUNK_WIDTH-bit chunks, then issues a shared active-low write.
`ifndef HV_DIMENSION
`define HV_DIMENSION 2000
`endif

module hv_memory_loader_eeg #(
    parameter int CHUNK_WIDTH     = 40,
    parameter int NUM_ROWS        = 112,
    parameter int SRAM_ADDR_WIDTH = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CHUNK_WIDTH-1:0]     in_data,
    output logic                       we,
    output logic [SRAM_ADDR_WIDTH-1:0] mem_addr,
    output logic [`HV_DIMENSION-1:0]   im_din,
    output logic [`HV_DIMENSION-1:0]   projm_pos_din,
    output logic [`HV_DIMENSION-1:0]   projm_neg_din,
    output logic                       busy,
    output logic                       done
);

    localparam int HV  = `HV_DIMENSION;
    localparam int CPH = HV / CHUNK_WIDTH;
    localparam int KW  = (CPH > 1) ? $clog2(CPH) : 1;
    localparam logic [KW-1:0]              K_LAST   = KW'(CPH - 1);
    localparam logic [SRAM_ADDR_WIDTH-1:0] ROW_LAST = SRAM_ADDR_WIDTH'(NUM_ROWS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;
    typedef enum logic [1:0] {SEG_IM, SEG_POS, SEG_NEG} seg_t;

    state_t                     r_state;
    seg_t                       r_seg;
    logic [KW-1:0]              r_k;
    logic [SRAM_ADDR_WIDTH-1:0] r_row;
    logic [SRAM_ADDR_WIDTH-1:0] r_addr;
    logic                       r_we;
    logic                       r_in_ready;
    logic                       r_busy;
    logic                       r_done;
    logic [HV-1:0]              r_im;
    logic [HV-1:0]              r_pos;
    logic [HV-1:0]              r_neg;

    logic                       w_hs;
    logic [31:0]                w_base;

    // The chunk counter is kept as (segment, index-in-segment) so no divide is needed.
    assign w_hs   = in_valid & r_in_ready;
    assign w_base = 32'(r_k) * CHUNK_WIDTH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_seg      <= SEG_IM;
            r_k        <= '0;
            r_row      <= '0;
            r_addr     <= '0;
            r_we       <= 1'b1;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_im       <= '0;
            r_pos      <= '0;
            r_neg      <= '0;
        end else begin
            r_done <= 1'b0;
            r_we   <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_LOAD;
                        r_row      <= '0;
                        r_k        <= '0;
                        r_seg      <= SEG_IM;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_hs) begin
                        case (r_seg)
                            SEG_IM:  r_im[w_base +: CHUNK_WIDTH]  <= in_data;
                            SEG_POS: r_pos[w_base +: CHUNK_WIDTH] <= in_data;
                            default: r_neg[w_base +: CHUNK_WIDTH] <= in_data;
                        endcase
                        if (r_k == K_LAST) begin
                            r_k <= '0;
                            if (r_seg == SEG_NEG) begin
                                r_seg      <= SEG_IM;
                                r_state    <= S_WRITE;
                                r_we       <= 1'b0;
                                r_addr     <= r_row;
                                r_in_ready <= 1'b0;
                            end else begin
                                r_seg <= (r_seg == SEG_IM) ? SEG_POS : SEG_NEG;
                            end
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (r_row == ROW_LAST) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_row      <= r_row + 1'b1;
                        r_state    <= S_LOAD;
                        r_in_ready <= 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign we            = r_we;
    assign mem_addr      = r_addr;
    assign im_din        = r_im;
    assign projm_pos_din = r_pos;
    assign projm_neg_din = r_neg;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

// File: tb/tb_hv_memory_loader_eeg.sv
// Scoreboard bench for hv_memory_loader_eeg: driver queues expected rows, monitor checks each write strobe.
`ifndef HV_DIMENSION
`define HV_DIMENSION 2000
`endif

module tb_hv_memory_loader_eeg;

    localparam int CW  = 40;
    localparam int NR  = 112;
    localparam int AW  = 7;
    localparam int HV  = `HV_DIMENSION;
    localparam int CPH = HV / CW;
    localparam int CPR = 3 * CPH;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b1;
    logic          start    = 1'b0;
    logic          in_valid = 1'b0;
    logic [CW-1:0] in_data  = '0;
    logic          in_ready;
    logic          we;
    logic [AW-1:0] mem_addr;
    logic [HV-1:0] im_din;
    logic [HV-1:0] projm_pos_din;
    logic [HV-1:0] projm_neg_din;
    logic          busy;
    logic          done;

    hv_memory_loader_eeg #(
        .CHUNK_WIDTH     (CW),
        .NUM_ROWS        (NR),
        .SRAM_ADDR_WIDTH (AW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .we            (we),
        .mem_addr      (mem_addr),
        .im_din        (im_din),
        .projm_pos_din (projm_pos_din),
        .projm_neg_din (projm_neg_din),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [HV-1:0] im;
        logic [HV-1:0] pos;
        logic [HV-1:0] neg;
    } row_t;

    row_t        sb[$];
    int unsigned n_vec     = 0;
    int unsigned n_fail    = 0;
    int unsigned done_seen = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_wide(input string nm, input int addr, input logic [HV-1:0] act,
                            input logic [HV-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got[63:0] %h, expected[63:0] %h", nm, addr,
                     act[63:0], exp[63:0]);
        end
    endtask

    // Monitor: every write strobe pops one expected row; done must follow the last-row write.
    logic          prev_last_wr;
    logic [AW-1:0] prev_addr;
    int unsigned   wr_cnt;

    always @(negedge clk) begin
        row_t e;
        if (!rst_n) begin
            prev_last_wr = 1'b0;
            prev_addr    = '0;
            wr_cnt       = 0;
        end else begin
            if (we) chk("addr_hold", 64'(mem_addr), 64'(prev_addr));
            if (!we) begin
                chk("ready_low_in_write", 64'(in_ready), 64'(0));
                chk("busy_in_write", 64'(busy), 64'(1));
                if (sb.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0d, expected no write", mem_addr);
                end else begin
                    e = sb.pop_front();
                    chk("write_addr", 64'(mem_addr), 64'(e.addr));
                    chk_wide("im_din", int'(e.addr), im_din, e.im);
                    chk_wide("projm_pos_din", int'(e.addr), projm_pos_din, e.pos);
                    chk_wide("projm_neg_din", int'(e.addr), projm_neg_din, e.neg);
                end
                wr_cnt++;
            end
            chk("done_timing", 64'(done), 64'(prev_last_wr));
            if (done) begin
                chk("busy_in_done", 64'(busy), 64'(0));
                chk("write_count", 64'(wr_cnt), 64'(NR));
                done_seen++;
                wr_cnt = 0;
            end
            prev_last_wr = !we && (mem_addr == AW'(NR - 1));
            prev_addr    = mem_addr;
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_we"},       64'(we),       64'(1));
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        chk({tag, "_busy"},     64'(busy),     64'(0));
        chk({tag, "_done"},     64'(done),     64'(0));
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
        chk({tag, "_dins_zero"}, 64'(|{im_din, projm_pos_din, projm_neg_din}), 64'(0));
    endtask

    task automatic send_chunk(input logic [CW-1:0] d, input int unsigned stall_pct,
                              input logic pulse_start);
        int unsigned guard = 0;
        while ($urandom_range(99) < stall_pct) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        start    = pulse_start;
        while (!in_ready) begin
            @(posedge clk); #1;
            start = 1'b0;
            guard++;
            if (guard > 50) begin
                $display("FAIL in_ready_timeout: in_ready stayed 0, expected 1");
                $fatal(1, "bounded wait expired");
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic send_row(input int r, input int unsigned stall_pct, input bit idx_pat,
                            input int abort_chunk, output bit aborted);
        logic [CW-1:0]    ch[CPR];
        logic [3*HV-1:0]  stream;
        row_t             e;
        aborted = 1'b0;
        stream  = '0;
        for (int c = 0; c < CPR; c++) begin
            ch[c]  = idx_pat ? CW'(c) : CW'({$urandom(), $urandom()});
            // Shift in from the top so the first chunk ends up at the LSB of the row stream.
            stream = {ch[c], stream[3*HV-1:CW]};
        end
        e.addr = AW'(r);
        e.im   = stream[HV-1:0];
        e.pos  = stream[2*HV-1:HV];
        e.neg  = stream[3*HV-1:2*HV];
        sb.push_back(e);
        for (int c = 0; c < CPR; c++) begin
            if (c == abort_chunk) begin
                rst_n = 1'b0;
                #1;
                chk_reset_outputs("abort");
                sb.delete();
                @(posedge clk);
                @(posedge clk); #1;
                rst_n   = 1'b1;
                aborted = 1'b1;
                return;
            end
            send_chunk(ch[c], stall_pct, (r == 5) && (c == 20));
        end
    endtask

    task automatic run_seq(input int unsigned stall_pct, input bit idx_row0, input int abort_row);
        bit          ab;
        int unsigned d0;
        int unsigned guard;
        in_valid = 1'b1;
        in_data  = '1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("idle_not_ready", 64'(in_ready), 64'(0));
        end
        in_valid = 1'b0;
        d0    = done_seen;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(1));
        for (int r = 0; r < NR; r++) begin
            send_row(r, stall_pct, idx_row0 && (r == 0), (r == abort_row) ? 73 : -1, ab);
            if (ab) return;
        end
        guard = 0;
        while (done_seen == d0 && guard < 5) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("done_seen", 64'(done_seen), 64'(d0 + 1));
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        chk("idle_busy_low", 64'(busy), 64'(0));
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("por");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        run_seq(0, 1'b1, 40);
        run_seq(0, 1'b1, -1);
        run_seq(50, 1'b0, -1);
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
